// File: rtl/hazard_stall_ctrl.sv
// ============================================================================
//  Module      : hazard_stall_ctrl
//  Description : Load-use / MDU-occupancy stall and exception flush control
//                for the 5-stage delay-slot MIPS pipeline.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_stall_ctrl #(
    parameter int MDU_LATENCY = 32,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic             id_is_mdu,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_wr_reg,
    input  logic             ex_mdu_start,
    input  logic             mem_exception,
    output logic             pc_we,
    output logic [1:0]       ifid_choice,
    output logic [1:0]       idex_choice,
    output logic [1:0]       exmem_choice,
    output logic [1:0]       memwb_choice,
    output logic             mdu_busy,
    output logic             mdu_cancel,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int             CW          = (MDU_LATENCY > 1) ? $clog2(MDU_LATENCY) : 1;
    localparam logic [CW-1:0]  C_CNT_LOAD  = CW'(MDU_LATENCY - 1);
    localparam logic [1:0]     C_FLUSH     = 2'b00;
    localparam logic [1:0]     C_LOAD      = 2'b01;
    localparam logic [1:0]     C_HOLD      = 2'b10;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
    logic               w_load_use;
    logic               w_mdu_stall;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // An MDU start seen while already BUSY is illegal and simply ignored.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        mdu_cancel = 1'b0;
        case (state_q)
            IDLE: begin
                if (ex_mdu_start) begin
                    if (mem_exception) begin
                        mdu_cancel = 1'b1;
                    end else begin
                        state_d = BUSY;
                        cnt_d   = C_CNT_LOAD;
                    end
                end
            end
            BUSY: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign mdu_busy = (state_q == BUSY);

    // Writes to $0 are discarded, so a load targeting it can never create a hazard.
    assign w_load_use = ex_mem_read && (ex_wr_reg != 5'd0) &&
                        ((id_use_rs && (id_rs == ex_wr_reg)) ||
                         (id_use_rt && (id_rt == ex_wr_reg)));

    assign w_mdu_stall = id_is_mdu && (mdu_busy || ex_mdu_start);

    always_comb begin
        pc_we        = 1'b1;
        ifid_choice  = C_LOAD;
        idex_choice  = C_LOAD;
        exmem_choice = C_LOAD;
        memwb_choice = C_LOAD;
        if (mem_exception) begin
            ifid_choice  = C_FLUSH;
            idex_choice  = C_FLUSH;
            exmem_choice = C_FLUSH;
            memwb_choice = C_FLUSH;
        end else if (w_mdu_stall || w_load_use) begin
            pc_we        = 1'b0;
            ifid_choice  = C_HOLD;
            idex_choice  = C_FLUSH;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (!pc_we && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    assign stall_cnt = stall_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_hazard_stall_ctrl.sv
// ============================================================================
//  Module      : tb_hazard_stall_ctrl
//  Description : Directed + random bench for hazard_stall_ctrl against a
//                cycle-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hazard_stall_ctrl;

    localparam int MDU_LATENCY = 4;
    localparam int CNT_W       = 5;
    localparam int CNT_MAX     = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             reset;
    logic [4:0]       id_rs, id_rt, ex_wr_reg;
    logic             id_use_rs, id_use_rt, id_is_mdu;
    logic             ex_mem_read, ex_mdu_start, mem_exception;
    logic             pc_we, mdu_busy, mdu_cancel;
    logic [1:0]       ifid_choice, idex_choice, exmem_choice, memwb_choice;
    logic [CNT_W-1:0] stall_cnt;

    int nvec = 0;
    int nerr = 0;

    // Reference state: cycles of MDU occupancy left, and stall-cycle tally.
    int m_busy_left = 0;
    int m_stalls    = 0;

    hazard_stall_ctrl #(.MDU_LATENCY(MDU_LATENCY), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .id_is_mdu(id_is_mdu), .ex_mem_read(ex_mem_read), .ex_wr_reg(ex_wr_reg),
        .ex_mdu_start(ex_mdu_start), .mem_exception(mem_exception),
        .pc_we(pc_we), .ifid_choice(ifid_choice), .idex_choice(idex_choice),
        .exmem_choice(exmem_choice), .memwb_choice(memwb_choice),
        .mdu_busy(mdu_busy), .mdu_cancel(mdu_cancel), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    // {pc_we, ifid, idex, exmem, memwb, mdu_busy, mdu_cancel}
    function automatic logic [10:0] model_out();
        bit busy, lu, stall, cancel;
        busy   = (m_busy_left > 0);
        lu     = ex_mem_read && ex_wr_reg != 0 &&
                 ((id_use_rs && id_rs == ex_wr_reg) || (id_use_rt && id_rt == ex_wr_reg));
        stall  = (id_is_mdu && (busy || ex_mdu_start)) || lu;
        cancel = !busy && ex_mdu_start && mem_exception;
        if (mem_exception) return {1'b1, 8'b00_00_00_00, busy, cancel};
        if (stall)         return {1'b0, 8'b10_00_01_01, busy, cancel};
        return {1'b1, 8'b01_01_01_01, busy, cancel};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp)
        else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_now(input string tag);
        chk({tag, ".ctl"}, 32'({pc_we, ifid_choice, idex_choice, exmem_choice,
                               memwb_choice, mdu_busy, mdu_cancel}), 32'(model_out()));
        chk({tag, ".cnt"}, 32'(stall_cnt), 32'(m_stalls));
    endtask

    // Advance the model to the state it should hold after the coming rising edge.
    task automatic model_step();
        logic [10:0] o;
        o = model_out();
        if (reset) begin
            m_busy_left = 0;
            m_stalls    = 0;
        end else begin
            if (!o[10] && m_stalls < CNT_MAX) m_stalls++;
            if (m_busy_left > 0)                        m_busy_left--;
            else if (ex_mdu_start && !mem_exception)    m_busy_left = MDU_LATENCY;
        end
    endtask

    task automatic apply(input string tag,
                         input logic [4:0] rs, input logic [4:0] rt,
                         input logic urs, input logic urt, input logic mdu,
                         input logic mr, input logic [4:0] wr,
                         input logic start, input logic exc);
        @(negedge clk);
        id_rs = rs; id_rt = rt; id_use_rs = urs; id_use_rt = urt; id_is_mdu = mdu;
        ex_mem_read = mr; ex_wr_reg = wr; ex_mdu_start = start; mem_exception = exc;
        #1;
        check_now(tag);
        model_step();
    endtask

    initial begin
        reset = 1'b1;
        {id_rs, id_rt, ex_wr_reg} = '0;
        {id_use_rs, id_use_rt, id_is_mdu, ex_mem_read, ex_mdu_start, mem_exception} = '0;
        #1;
        check_now("reset_idle");
        chk("reset_const", 32'({pc_we, ifid_choice, idex_choice, exmem_choice, memwb_choice,
                               mdu_busy, mdu_cancel}), 32'b1_01_01_01_01_0_0);
        apply("reset_hold", 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        reset = 1'b0;

        // lw $5 in EX, add in ID reads $5
        apply("lu_stall", 5, 7, 1, 1, 0, 1, 5, 0, 0);
        apply("lu_after", 6, 7, 1, 1, 0, 0, 0, 0, 0);
        chk("lu_cnt1", 32'(stall_cnt), 32'd1);
        // rt-side hazard, and rt match without use flag
        apply("lu_rt", 1, 9, 1, 1, 0, 1, 9, 0, 0);
        apply("lu_rt_nouse", 1, 9, 1, 0, 0, 1, 9, 0, 0);
        // load to $0
        apply("lu_zero", 0, 0, 1, 1, 0, 1, 0, 0, 0);
        // exception beats load-use
        apply("exc_lu", 5, 5, 1, 1, 0, 1, 5, 0, 1);

        // mult starts, mflo in ID afterwards: stalls while busy, then proceeds
        apply("mdu_start", 0, 0, 0, 0, 0, 0, 0, 1, 0);
        for (int i = 0; i < MDU_LATENCY + 2; i++)
            apply($sformatf("mflo_%0d", i), 0, 0, 0, 0, 1, 0, 0, 0, 0);

        // start cancelled by a simultaneous exception
        apply("cancel", 0, 0, 0, 0, 0, 0, 0, 1, 1);
        apply("cancel_idle", 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // exception during BUSY leaves countdown intact; stray start is ignored
        apply("busy_start", 0, 0, 0, 0, 0, 0, 0, 1, 0);
        apply("busy_exc", 0, 0, 0, 0, 0, 0, 0, 0, 1);
        apply("busy_stray", 0, 0, 0, 0, 0, 0, 0, 1, 1);
        for (int i = 0; i < MDU_LATENCY; i++)
            apply($sformatf("busy_run_%0d", i), 0, 0, 0, 0, 1, 0, 0, 0, 0);

        // asynchronous reset in the middle of BUSY
        apply("rst_start", 0, 0, 0, 0, 0, 0, 0, 1, 0);
        apply("rst_busy1", 0, 0, 0, 0, 1, 0, 0, 0, 0);
        @(negedge clk);
        #2;
        reset = 1'b1;
        m_busy_left = 0;
        m_stalls    = 0;
        #1;
        check_now("rst_async");
        chk("rst_busy0", 32'(mdu_busy), 32'd0);
        apply("rst_held", 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        reset = 1'b0;
        apply("rst_release", 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // random traffic drawn from a small register pool so hazards occur often
        for (int i = 0; i < 500; i++) begin
            apply("rand",
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  1'($urandom), 1'($urandom), ($urandom_range(0, 2) == 0),
                  1'($urandom), 5'($urandom_range(0, 3)),
                  ($urandom_range(0, 5) == 0), ($urandom_range(0, 9) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

`default_nettype wire
